// File: rtl/hub75_pkg.sv
// hub75_pkg
// Types and constants shared by the HUB75 driver and the HUB75 capture block.
//   rgb_t          : one pixel as packed {r,g,b}
//   HUB75_RGB_W    : bits per pixel on each rgb pin group
//   HUB75_OE_CNT_W : width of the output-enable cycle counter
//   cap_state_t    : capture output buffer state
package hub75_pkg;

   localparam int HUB75_RGB_W    = 3;
   localparam int HUB75_OE_CNT_W = 16;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

   typedef enum logic [0:0] {
      CAP_EMPTY = 1'b0,
      CAP_FULL  = 1'b1
   } cap_state_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// hub75_sync_edge
// Synchronizes an asynchronous pin bundle into the clk domain and flags rising
// edges on the lowest EDGE_W lanes. The whole bundle moves through the same
// flops, so data lanes stay aligned with the edge flags.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   din  : raw asynchronous pins
//   dout : synchronized bundle, aligned with rise
//   rise : one-cycle pulse per rising edge on din[EDGE_W-1:0]
// Fewer than two synchronizer stages are raised to two.
module hub75_sync_edge #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_W      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic [EDGE_W-1:0] rise
);

   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [WIDTH-1:0]  chain_r [STAGES];
   logic [WIDTH-1:0]  prev_r;
   logic [EDGE_W-1:0] rise_r;

   // Synchronizer chain, one extra copy and registered rise detect.
   // prev_r holds the value that produced rise_r, so dout is taken from it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            chain_r[i] <= '0;
         end
         prev_r <= '0;
         rise_r <= '0;
      end else begin
         chain_r[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            chain_r[i] <= chain_r[i-1];
         end
         prev_r <= chain_r[STAGES-1];
         rise_r <= chain_r[STAGES-1][EDGE_W-1:0] & ~prev_r[EDGE_W-1:0];
      end
   end

   assign dout = prev_r;
   assign rise = rise_r;

endmodule

// File: rtl/hub75_capture.sv
// hub75_capture
// Listens to a HUB75 panel bus and rebuilds each latched row pair into one
// parallel beat offered on a valid/ready handshake.
// Ports:
//   clk_in, rst_in          : system clock, synchronous active-high reset
//   hub75_*_in              : raw HUB75 pins (clk, rgb0, rgb1, latch, oe_n, addr)
//   row_valid_out/ready_in  : beat handshake
//   row_addr_out            : row address sampled at latch
//   row0_out/row1_out       : upper/lower rows, pixel c at bits [3c+2:3c]
//   shift_count_out         : shift pulses before latch (saturating)
//   length_err_out          : shift count differed from NUM_COLS
//   overrun_out             : sticky, a latch arrived while a beat was pending
//   oe_cycles_out           : OE-low cycles in the previous latch period
// Optional feature macro: HUB75_CAPTURE_OE_TIMER_EN enables the OE-low timer;
// without it oe_cycles_out is constant zero.
module hub75_capture
   import hub75_pkg::*;
#(
   parameter int NUM_COLS    = 64,
   parameter int SCAN_RATE   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                               clk_in,
   input  logic                               rst_in,
   input  logic                               hub75_clk_in,
   input  logic [2:0]                         hub75_rgb0_in,
   input  logic [2:0]                         hub75_rgb1_in,
   input  logic                               hub75_latch_in,
   input  logic                               hub75_oe_in,
   input  logic [$clog2(SCAN_RATE)-1:0]       hub75_addr_in,
   output logic                               row_valid_out,
   input  logic                               row_ready_in,
   output logic [$clog2(SCAN_RATE)-1:0]       row_addr_out,
   output logic [NUM_COLS*3-1:0]              row0_out,
   output logic [NUM_COLS*3-1:0]              row1_out,
   output logic [$clog2(NUM_COLS)+1:0]        shift_count_out,
   output logic                               length_err_out,
   output logic                               overrun_out,
   output logic [15:0]                        oe_cycles_out
);

   localparam int ADDR_W = $clog2(SCAN_RATE);
   localparam int CNT_W  = $clog2(NUM_COLS) + 2;
   localparam int ROW_W  = NUM_COLS * HUB75_RGB_W;
   // Bundle lanes: {addr, oe_n, rgb1, rgb0, latch, clk}
   localparam int BUS_W  = ADDR_W + 2 * HUB75_RGB_W + 3;
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(2 * NUM_COLS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_COLS);

   logic [BUS_W-1:0]  pins_s;
   logic [BUS_W-1:0]  synced_s;
   logic [1:0]        rise_s;
   logic              shift_rise_s;
   logic              latch_rise_s;
   rgb_t              rgb0_s;
   rgb_t              rgb1_s;
   logic              oe_low_s;
   logic [ADDR_W-1:0] addr_s;

   logic [ROW_W-1:0]  row0_sh_r;
   logic [ROW_W-1:0]  row1_sh_r;
   logic [CNT_W-1:0]  shift_cnt_r;
   logic [ROW_W-1:0]  row0_nx_s;
   logic [ROW_W-1:0]  row1_nx_s;
   logic [CNT_W-1:0]  cnt_nx_s;

   cap_state_t        state_r;
   logic              load_s;
   logic              valid_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ROW_W-1:0]  row0_r;
   logic [ROW_W-1:0]  row1_r;
   logic [CNT_W-1:0]  count_r;
   logic              len_err_r;
   logic              overrun_r;

   assign pins_s = {hub75_addr_in, hub75_oe_in, hub75_rgb1_in, hub75_rgb0_in,
                    hub75_latch_in, hub75_clk_in};

   hub75_sync_edge #(
      .WIDTH       (BUS_W),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_W      (2)
   ) u_sync (
      .clk  (clk_in),
      .rst  (rst_in),
      .din  (pins_s),
      .dout (synced_s),
      .rise (rise_s)
   );

   assign shift_rise_s = rise_s[0];
   assign latch_rise_s = rise_s[1];
   assign rgb0_s       = rgb_t'(synced_s[4:2]);
   assign rgb1_s       = rgb_t'(synced_s[7:5]);
   assign oe_low_s     = ~synced_s[8];
   assign addr_s       = synced_s[BUS_W-1:9];

   // Shift-register next state; a latch in the same cycle captures these
   // values, so the coinciding pixel is included in the beat.
   always_comb begin
      row0_nx_s = row0_sh_r;
      row1_nx_s = row1_sh_r;
      cnt_nx_s  = shift_cnt_r;
      if (shift_rise_s) begin
         row0_nx_s = {rgb0_s, row0_sh_r[ROW_W-1:HUB75_RGB_W]};
         row1_nx_s = {rgb1_s, row1_sh_r[ROW_W-1:HUB75_RGB_W]};
         if (shift_cnt_r != CNT_SAT) begin
            cnt_nx_s = shift_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_nx_s = shift_cnt_r;
         end
      end else begin
         row0_nx_s = row0_sh_r;
         row1_nx_s = row1_sh_r;
         cnt_nx_s  = shift_cnt_r;
      end
   end

   // Pixel shift registers and shift counter; latch clears only the counter.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         row0_sh_r   <= '0;
         row1_sh_r   <= '0;
         shift_cnt_r <= '0;
      end else begin
         row0_sh_r   <= row0_nx_s;
         row1_sh_r   <= row1_nx_s;
         shift_cnt_r <= latch_rise_s ? '0 : cnt_nx_s;
      end
   end

   // A new beat is taken when the buffer is empty or is being drained now.
   assign load_s = latch_rise_s & ((state_r == CAP_EMPTY) | row_ready_in);

   // Output buffer FSM with registered beat fields.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r   <= CAP_EMPTY;
         valid_r   <= 1'b0;
         addr_r    <= '0;
         row0_r    <= '0;
         row1_r    <= '0;
         count_r   <= '0;
         len_err_r <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         if (load_s) begin
            addr_r    <= addr_s;
            row0_r    <= row0_nx_s;
            row1_r    <= row1_nx_s;
            count_r   <= cnt_nx_s;
            len_err_r <= (cnt_nx_s != CNT_FULL);
         end
         case (state_r)
            CAP_EMPTY: begin
               if (latch_rise_s) begin
                  state_r <= CAP_FULL;
                  valid_r <= 1'b1;
               end
            end
            CAP_FULL: begin
               if (latch_rise_s) begin
                  // Without ready the new row is dropped and the held beat kept.
                  if (!row_ready_in) begin
                     overrun_r <= 1'b1;
                  end
               end else if (row_ready_in) begin
                  state_r <= CAP_EMPTY;
                  valid_r <= 1'b0;
               end
            end
            default: begin
               state_r <= CAP_EMPTY;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign row_valid_out   = valid_r;
   assign row_addr_out    = addr_r;
   assign row0_out        = row0_r;
   assign row1_out        = row1_r;
   assign shift_count_out = count_r;
   assign length_err_out  = len_err_r;
   assign overrun_out     = overrun_r;

`ifdef HUB75_CAPTURE_OE_TIMER_EN
   logic [HUB75_OE_CNT_W-1:0] oe_cnt_r;
   logic [HUB75_OE_CNT_W-1:0] oe_cycles_r;
   logic                      unused_lanes_s;

   // OE-low cycle counter; restarts on every latch, counting that cycle too.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         oe_cnt_r    <= '0;
         oe_cycles_r <= '0;
      end else begin
         if (latch_rise_s) begin
            oe_cnt_r <= oe_low_s ? 16'd1 : 16'd0;
         end else if (oe_low_s && (oe_cnt_r != 16'hFFFF)) begin
            oe_cnt_r <= oe_cnt_r + 16'd1;
         end
         if (load_s) begin
            oe_cycles_r <= oe_cnt_r;
         end
      end
   end

   assign oe_cycles_out  = oe_cycles_r;
   assign unused_lanes_s = ^synced_s[1:0];
`else
   logic unused_lanes_s;

   assign oe_cycles_out  = 16'd0;
   assign unused_lanes_s = ^{synced_s[1:0], oe_low_s};
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture
// Directed bench for hub75_capture: reset state, full row capture and latency,
// short/saturated rows, overrun, mid-row reset, back-to-back beats and,
// when HUB75_CAPTURE_OE_TIMER_EN is defined, the OE-low timer.
module tb_hub75_capture;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         hclk = 1'b0;
   logic [2:0]   rgb0 = 3'd0;
   logic [2:0]   rgb1 = 3'd0;
   logic         latch = 1'b0;
   logic         oe = 1'b1;
   logic [4:0]   addr = 5'd0;
   logic         valid;
   logic         ready = 1'b0;
   logic [4:0]   row_addr;
   logic [191:0] row0;
   logic [191:0] row1;
   logic [7:0]   count;
   logic         len_err;
   logic         overrun;
   logic [15:0]  oe_cycles;

   int checks = 0;
   int errors = 0;

   hub75_capture #(.NUM_COLS(64), .SCAN_RATE(32), .SYNC_STAGES(2)) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .hub75_clk_in    (hclk),
      .hub75_rgb0_in   (rgb0),
      .hub75_rgb1_in   (rgb1),
      .hub75_latch_in  (latch),
      .hub75_oe_in     (oe),
      .hub75_addr_in   (addr),
      .row_valid_out   (valid),
      .row_ready_in    (ready),
      .row_addr_out    (row_addr),
      .row0_out        (row0),
      .row1_out        (row1),
      .shift_count_out (count),
      .length_err_out  (len_err),
      .overrun_out     (overrun),
      .oe_cycles_out   (oe_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [2:0] a, input logic [2:0] b);
      rgb0 = a;
      rgb1 = b;
      hclk = 1'b1;
      tick(2);
      hclk = 1'b0;
      tick(2);
   endtask

   task automatic latch_row(input logic [4:0] a);
      addr  = a;
      latch = 1'b1;
      tick(2);
      latch = 1'b0;
      tick(2);
   endtask

   task automatic shift_pattern(input int n);
      logic [2:0] p;
      for (int c = 0; c < n; c++) begin
         p = 3'(c);
         pulse(p, ~p);
      end
   endtask

   task automatic accept();
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
   endtask

   function automatic logic [191:0] exp_row(input logic inv);
      logic [191:0] r;
      logic [2:0]   p;
      r = '0;
      for (int c = 0; c < 64; c++) begin
         p = 3'(c);
         r[3*c +: 3] = inv ? ~p : p;
      end
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h expected 0", valid); end
      checks++; if (row_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0h expected 0", row_addr); end
      checks++; if (row0 !== 192'd0) begin errors++; $display("FAIL reset_row0 got %0h expected 0", row0); end
      checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
      checks++; if (overrun !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b%0b expected 00", overrun, len_err); end
      checks++; if (oe_cycles !== 16'd0) begin errors++; $display("FAIL reset_oe got %0d expected 0", oe_cycles); end
   endtask

   task automatic test_full_row();
      shift_pattern(64);
      addr  = 5'd5;
      latch = 1'b1;
      tick(3);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL latency_early got %0b expected 0", valid); end
      tick(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %0b expected 1", valid); end
      latch = 1'b0;
      tick(2);
      checks++; if (row_addr !== 5'd5) begin errors++; $display("FAIL full_addr got %0d expected 5", row_addr); end
      checks++; if (row0 !== exp_row(1'b0)) begin errors++; $display("FAIL full_row0 got %0h expected %0h", row0, exp_row(1'b0)); end
      checks++; if (row1 !== exp_row(1'b1)) begin errors++; $display("FAIL full_row1 got %0h expected %0h", row1, exp_row(1'b1)); end
      checks++; if (count !== 8'd64) begin errors++; $display("FAIL full_count got %0d expected 64", count); end
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL full_lenerr got %0b expected 0", len_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_overrun got %0b expected 0", overrun); end
      accept();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL full_accept got %0b expected 0", valid); end
   endtask

   task automatic test_length();
      shift_pattern(60);
      latch_row(5'd9);
      checks++; if (count !== 8'd60 || len_err !== 1'b1) begin errors++; $display("FAIL short_row got count %0d err %0b expected 60 1", count, len_err); end
      accept();
      shift_pattern(64);
      latch_row(5'd10);
      checks++; if (count !== 8'd64 || len_err !== 1'b0) begin errors++; $display("FAIL next_row got count %0d err %0b expected 64 0", count, len_err); end
      checks++; if (row_addr !== 5'd10) begin errors++; $display("FAIL next_row_addr got %0d expected 10", row_addr); end
      accept();
      shift_pattern(130);
      latch_row(5'd11);
      checks++; if (count !== 8'd127 || len_err !== 1'b1) begin errors++; $display("FAIL sat_row got count %0d err %0b expected 127 1", count, len_err); end
      accept();
   endtask

   task automatic test_overrun();
      shift_pattern(4);
      latch_row(5'd3);
      latch_row(5'd4);
      checks++; if (valid !== 1'b1 || row_addr !== 5'd3) begin errors++; $display("FAIL overrun_hold got valid %0b addr %0d expected 1 3", valid, row_addr); end
      checks++; if (count !== 8'd4) begin errors++; $display("FAIL overrun_count got %0d expected 4", count); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %0b expected 1", overrun); end
      accept();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL overrun_accept got %0b expected 0", valid); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b expected 1", overrun); end
   endtask

   task automatic test_midrow_reset();
      shift_pattern(30);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++; if (overrun !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL midreset_flags got ovr %0b valid %0b expected 0 0", overrun, valid); end
      checks++; if (row_addr !== 5'd0 || count !== 8'd0 || row0 !== 192'd0 || row1 !== 192'd0) begin errors++; $display("FAIL midreset_beat got addr %0d count %0d expected 0 0", row_addr, count); end
      tick(2);
      shift_pattern(64);
      latch_row(5'd7);
      checks++; if (count !== 8'd64 || len_err !== 1'b0) begin errors++; $display("FAIL midreset_count got %0d err %0b expected 64 0", count, len_err); end
      checks++; if (row0 !== exp_row(1'b0) || row_addr !== 5'd7) begin errors++; $display("FAIL midreset_row got %0h expected %0h", row0, exp_row(1'b0)); end
      accept();
   endtask

   task automatic test_back_to_back();
      shift_pattern(2);
      latch_row(5'd3);
      addr  = 5'd4;
      latch = 1'b1;
      tick(3);
      ready = 1'b1;
      checks++; if (valid !== 1'b1 || row_addr !== 5'd3) begin errors++; $display("FAIL b2b_first got valid %0b addr %0d expected 1 3", valid, row_addr); end
      tick(1);
      latch = 1'b0;
      checks++; if (valid !== 1'b1 || row_addr !== 5'd4) begin errors++; $display("FAIL b2b_second got valid %0b addr %0d expected 1 4", valid, row_addr); end
      checks++; if (overrun !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL b2b_flags got ovr %0b count %0d expected 0 0", overrun, count); end
      tick(1);
      ready = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b expected 0", valid); end
   endtask

`ifdef HUB75_CAPTURE_OE_TIMER_EN
   task automatic test_oe_timer();
      latch_row(5'd1);
      accept();
      oe = 1'b0;
      tick(200);
      oe = 1'b1;
      tick(4);
      latch_row(5'd2);
      checks++; if (oe_cycles !== 16'd200) begin errors++; $display("FAIL oe_200 got %0d expected 200", oe_cycles); end
      accept();
      oe = 1'b0;
      tick(70000);
      oe = 1'b1;
      tick(4);
      latch_row(5'd2);
      checks++; if (oe_cycles !== 16'hFFFF) begin errors++; $display("FAIL oe_sat got %0d expected 65535", oe_cycles); end
      accept();
   endtask
`endif

   initial begin
      test_reset();
      test_full_row();
      test_length();
      test_overrun();
      test_midrow_reset();
      test_back_to_back();
`ifdef HUB75_CAPTURE_OE_TIMER_EN
      test_oe_timer();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
